// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the
// iterative multiply/divide unit.
//   master: start, op, operandA, operandB, mtHiWrite, mtLoWrite, mtData (out)
//           busy, done, divByZero, hi, lo (in)
//   slave : mirror image of master
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             mtHiWrite;
    logic             mtLoWrite;
    logic [WIDTH-1:0] mtData;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operandA, operandB, mtHiWrite, mtLoWrite, mtData,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
        input  start, op, operandA, operandB, mtHiWrite, mtLoWrite, mtData,
        output busy, done, divByZero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO pair, with MTHI/MTLO.
// One operand bit is processed per clock; busy stalls dependent instructions.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : muldiv_unit_if.slave (start/op/operands/MT strobes in,
//           busy/done/divByZero/hi/lo out)
// Optional build macro MULDIV_DIV_EN: when defined, the restoring divider and
// DIV state are built; otherwise DIV/DIVU only pulse done with HI/LO unchanged.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] mcand;      // multiplicand, or divisor magnitude
    logic [PW-1:0]    acc;        // mul: {partial sum, multiplier}; div: {remainder, quotient}
    logic [CNT_W-1:0] counter;
    logic             neg_q;      // negate product / quotient at FIN
    logic             wr_en;      // FIN writes HI/LO
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Operand magnitudes; unsigned ops never see a negative sign.
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign sgn   = ~bus.op[0];
    assign a_neg = sgn & bus.operandA[WIDTH-1];
    assign b_neg = sgn & bus.operandB[WIDTH-1];
    assign abs_a = a_neg ? -bus.operandA : bus.operandA;
    assign abs_b = b_neg ? -bus.operandB : bus.operandB;

    // Shift-add step: conditionally add multiplicand into the upper half, shift right.
    logic [WIDTH:0]  mul_sum;
    logic [PW-1:0]   mul_next;
    logic [PW-1:0]   prod_res;

    always_comb begin
        mul_sum  = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        prod_res = neg_q ? -acc : acc;
    end

`ifdef MULDIV_DIV_EN
    logic             neg_r;      // remainder follows dividend sign
    logic             is_div;
    logic             dbz_pend;
    logic             dbz_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [PW-1:0]    div_next;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

    // Restoring step: shift next dividend bit into remainder, subtract if it fits.
    // The remainder stays below the divisor, so only the shifted value needs a carry bit.
    always_comb begin
        rem_sh   = {acc[PW-1:WIDTH], acc[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, mcand};
        if (rem_diff[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        quo_res = neg_q ? -acc[WIDTH-1:0]  : acc[WIDTH-1:0];
        rem_res = neg_r ? -acc[PW-1:WIDTH] : acc[PW-1:WIDTH];
    end

    assign bus.divByZero = dbz_q;
`else
    assign bus.divByZero = 1'b0;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mcand    <= '0;
            acc      <= '0;
            counter  <= '0;
            neg_q    <= 1'b0;
            wr_en    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_DIV_EN
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            dbz_pend <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            dbz_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        counter <= CNT_W'(WIDTH);
                        wr_en   <= 1'b1;
                        neg_q   <= a_neg ^ b_neg;
                        if (!bus.op[1]) begin
                            mcand  <= abs_a;
                            acc    <= {{WIDTH{1'b0}}, abs_b};
                            busy_q <= 1'b1;
                            state  <= MUL;
`ifdef MULDIV_DIV_EN
                            is_div   <= 1'b0;
                            dbz_pend <= 1'b0;
                        end else if (bus.operandB == '0) begin
                            // Preload the raw result and let FIN write it unsigned.
                            acc      <= {bus.operandA, {WIDTH{1'b1}}};
                            neg_q    <= 1'b0;
                            neg_r    <= 1'b0;
                            is_div   <= 1'b0;
                            dbz_pend <= 1'b1;
                            busy_q   <= 1'b1;
                            state    <= FIN;
                        end else begin
                            mcand    <= abs_b;
                            acc      <= {{WIDTH{1'b0}}, abs_a};
                            neg_r    <= a_neg;
                            is_div   <= 1'b1;
                            dbz_pend <= 1'b0;
                            busy_q   <= 1'b1;
                            state    <= DIV;
                        end
`else
                        end else begin
                            // No divider: complete immediately without touching HI/LO.
                            wr_en <= 1'b0;
                            state <= FIN;
                        end
`endif
                    end else begin
                        if (bus.mtHiWrite) hi_q <= bus.mtData;
                        if (bus.mtLoWrite) lo_q <= bus.mtData;
                    end
                end
                MUL: begin
                    acc     <= mul_next;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) state <= FIN;
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    acc     <= div_next;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) state <= FIN;
                end
`endif
                FIN: begin
                    if (wr_en) begin
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            hi_q <= rem_res;
                            lo_q <= quo_res;
                        end else begin
                            hi_q <= prod_res[PW-1:WIDTH];
                            lo_q <= prod_res[WIDTH-1:0];
                        end
                        dbz_q <= dbz_pend;
`else
                        hi_q <= prod_res[PW-1:WIDTH];
                        lo_q <= prod_res[WIDTH-1:0];
`endif
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit (WIDTH=32) against an
// arithmetic reference model of HI/LO, latency and busy duration.
module tb_muldiv_unit;
    localparam int unsigned W = 32;

    logic clk;
    logic reset;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operation.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl,
                                  output logic dz, output int lat, output int bsy);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dz  = 1'b0;
        lat = W + 1;
        bsy = W + 1;
        rh  = hi_m;
        rl  = lo_m;
        case (o)
            2'b00: begin
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, a} * {32'b0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == '0) begin
                    rh  = a;
                    rl  = '1;
                    dz  = 1'b1;
                    lat = 1;
                    bsy = 1;
                end else if (o == 2'b10) begin
                    q  = 64'(sa / sb);
                    r  = 64'(sa % sb);
                    rl = q[31:0];
                    rh = r[31:0];
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
`else
                lat = 1;
                bsy = 0;
`endif
            end
        endcase
    endfunction

    // Issue one op (optionally with MT strobes in the same cycle, or an
    // interfering start+MTLO pulse after 'inj' edges) and check the result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit mt_too, input int inj);
        int          edges;
        int          busy_cnt;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic        edz;
        int          elat;
        int          ebsy;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.operandA = a;
        bus.operandB = b;
        if (mt_too) begin
            bus.mtHiWrite = 1'b1;
            bus.mtLoWrite = 1'b1;
            bus.mtData    = $urandom;
        end
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.mtHiWrite = 1'b0;
        bus.mtLoWrite = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_cnt++;
            if (edges == inj) begin
                @(negedge clk);
                bus.start     = 1'b1;
                bus.op        = 2'b00;
                bus.operandA  = 32'd2;
                bus.operandB  = 32'd2;
                bus.mtLoWrite = 1'b1;
                bus.mtData    = 32'h1234;
                @(posedge clk);
                #1;
                bus.start     = 1'b0;
                bus.mtLoWrite = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            edges++;
        end
        model(o, a, b, eh, el, edz, elat, ebsy);
        hi_m = eh;
        lo_m = el;
        check({tag, "_latency"}, 64'(edges), 64'(elat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(ebsy));
        check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        check({tag, "_lo"}, 64'(bus.lo), 64'(el));
        check({tag, "_dbz"}, 64'(bus.divByZero), 64'(edz));
    endtask

    task automatic check_pulse_end(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 64'(bus.done), 64'(0));
        check({tag, "_dbz_drop"}, 64'(bus.divByZero), 64'(0));
    endtask

    task automatic mt_write(input logic hw, input logic lw, input logic [W-1:0] d);
        @(negedge clk);
        bus.mtHiWrite = hw;
        bus.mtLoWrite = lw;
        bus.mtData    = d;
        @(posedge clk);
        #1;
        bus.mtHiWrite = 1'b0;
        bus.mtLoWrite = 1'b0;
        if (hw) hi_m = d;
        if (lw) lo_m = d;
        check("mt_hi", 64'(bus.hi), 64'(hi_m));
        check("mt_lo", 64'(bus.lo), 64'(lo_m));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = 32'($urandom_range(0, 50));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        bit seen;
        n_tests = 0;
        n_fail  = 0;
        hi_m    = '0;
        lo_m    = '0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operandA  = '0;
        bus.operandB  = '0;
        bus.mtHiWrite = 1'b0;
        bus.mtLoWrite = 1'b0;
        bus.mtData    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_dbz", 64'(bus.divByZero), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        check_pulse_end("multu_max");
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, -1);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, -1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("divu_zero", 2'b11, 32'h64, 32'd0, 1'b0, -1);
        check_pulse_end("divu_zero");

        // Start + MTLO while busy are ignored
        run_op("interfere", 2'b01, 32'd5, 32'd6, 1'b0, 9);

        // Reset mid-operation aborts with no result
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = 2'b01;
        bus.operandA = 32'd5;
        bus.operandB = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_hi", 64'(bus.hi), 64'(0));
        check("midrst_lo", 64'(bus.lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        hi_m  = '0;
        lo_m  = '0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'(0));
        run_op("after_rst", 2'b01, 32'd5, 32'd6, 1'b0, -1);

        // MT writes in IDLE, and MT loses to a same-cycle start
        mt_write(1'b1, 1'b1, 32'hA5A5_A5A5);
        mt_write(1'b0, 1'b1, 32'h0000_1111);
        run_op("mt_vs_start", 2'b00, 32'd3, 32'hFFFF_FFFE, 1'b1, -1);

        // Randomized sequence; consecutive ops start in the done cycle
        for (int i = 0; i < 120; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = pick();
            b = pick();
            if ($urandom_range(0, 3) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op("rand", 2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 7) == 0), -1);
            if ($urandom_range(0, 3) == 0) check_pulse_end("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage of the pipelined MIPS core.
- Implements MULT, MULTU, DIV and DIVU into HI/LO registers, plus MTHI/MTLO writes.
- Replaces the single-cycle ALU path for these ops; busy goes to the hazard detection unit to stall MFHI/MFLO and a new mult/div until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch op; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operandA  input  WIDTH  multiplicand/dividend (rs).
- operandB  input  WIDTH  multiplier/divisor (rt).
- mtHiWrite  input  1  MTHI strobe.
- mtLoWrite  input  1  MTLO strobe.
- mtData  input  WIDTH  MTHI/MTLO data.
- busy  output  1  op in progress (registered).
- done  output  1  one-cycle pulse when HI/LO updated.
- divByZero  output  1  one-cycle pulse with done on a zero divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async): state=IDLE; busy, done, divByZero, hi, lo, counter all 0. A reset mid-operation aborts it; no result is written.
- States: IDLE, MUL, DIV, FIN.
- IDLE, start=1 at edge E0:
  - Latch absolute values of the operands (signed ops) or the raw operands (unsigned ops).
  - Latch the result sign flags.
  - counter=WIDTH; busy=1; go to MUL or DIV.
- MUL: shift-add, one multiplier bit per edge for WIDTH edges (E1..E_WIDTH), then FIN.
- DIV: restoring division, one quotient bit per edge for WIDTH edges, then FIN.
- FIN (edge E_WIDTH+1):
  - Apply sign correction.
  - Write hi/lo, busy=0, done=1 for exactly one cycle, back to IDLE.
- Latency: done is visible after WIDTH+1 edges following E0.
- Back-to-back: a new start may be accepted in the cycle done is high (state IDLE).
- Multiply result: full 2*WIDTH-bit product; hi = upper half, lo = lower half.
- Signed product is negated when operand signs differ.
- Division: quotient in lo, truncated toward zero; remainder in hi, taking the sign of the dividend.
- Overflow case -2^(WIDTH-1) / -1: lo=-2^(WIDTH-1) (0x80000000 at WIDTH 32), hi=0. No flag.
- Divide by zero (DIV/DIVU, operandB=0):
  - Skip iteration and go straight to FIN at E1.
  - hi=operandA, lo=all ones, done=1 and divByZero=1 for one cycle.
- start while busy (MUL/DIV/FIN): ignored; no latch, no effect.
- MTHI/MTLO:
  - In IDLE, write mtData into hi/lo at the next edge; both strobes may fire together.
  - When not IDLE: ignored.
  - Same cycle as an accepted start: start wins, strobes ignored.
- hi/lo hold their value except on FIN, an accepted MT write, or reset.

Optional Feature:
- Macro MULDIV_DIV_EN.
- Defined: DIV/DIVU behave as described above.
- Undefined:
  - No divider datapath or DIV state is built.
  - A start with op[1]=1 goes IDLE->FIN in one edge: hi/lo unchanged, done pulses, busy never asserts.
  - divByZero is tied to 0.
  - Multiply timing is unchanged.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> busy high 33 cycles; done pulse 33 edges after E0; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 (0xFFFFFFFD) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x64 / 0 -> done and divByZero both high the cycle after E1; hi=0x64, lo=0xFFFFFFFF. Without MULDIV_DIV_EN -> done only, hi/lo unchanged.
- Mid-operation interference:
  - Start MULTU 5*6.
  - At cycle 10, pulse start (MULT 2*2) and mtLoWrite (0x1234): both ignored, result hi=0, lo=30.
  - Rerun; assert reset at cycle 10: busy, hi, lo = 0 immediately, no done pulse.
  - A fresh start then completes normally.
- IDLE MT writes: mtHiWrite=1, mtLoWrite=1, mtData=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5 next cycle. Same cycle as an accepted start: MT ignored, multiply result written.
